alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
- Stage directly downstream of the ALU. Captures each ALU result (out, flags[Z,C,N,V]) together with destination register and control bits into a 2-entry skid buffer.
- Drains entries to the register-file write port under a valid/ready handshake.
- Commits flags into the architectural status register (NZCV).
- Evaluates ARM condition codes against the status register for the decode stage.

Parameters:
- DATA_W, 32, result/write-data width
- RADDR_W, 4, destination register index width (r0..r15)
- FLAGS_RST, 4'b0000, reset value of status register, order [Z,C,N,V]

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept an entry
- in_result  in  DATA_W  ALU out
- in_flags  in  4  ALU flags [Z,C,N,V]
- in_rd  in  RADDR_W  destination register
- in_wr_en  in  1  entry writes rd (0 for CMP-type uops)
- in_set_flags  in  1  entry updates status register
- rf_valid  out  1  write request to register file
- rf_ready  in  1  register file accepts write
- rf_addr  out  RADDR_W  write address
- rf_data  out  DATA_W  write data
- cond  in  4  ARM condition field from decode
- cond_pass  out  1  condition satisfied (combinational from flag source)
- status  out  4  architectural flags [Z,C,N,V]
- flags_pending  out  1  a buffered entry has set_flags=1

Behaviour:
- Buffer: 2 entries, FIFO order. Occupancy state EMPTY/ONE/FULL. The head entry drives the outputs.
- in_ready = (state != FULL). It is a function of registered state only; there is no combinational path from rf_ready to in_ready.
- Accept when in_valid & in_ready. Pop when head valid and (rf_ready or head.wr_en=0).
- rf_valid = head present & head.wr_en. Entries with wr_en=0 retire in one cycle without asserting rf_valid.
- Simultaneous accept+pop: occupancy unchanged, order preserved.
  - In FULL, accept is blocked even if a pop occurs that cycle.
  - In EMPTY, accept and pop never occur in the same cycle; minimum latency is 1 cycle from accept to rf_valid.
- rf_addr/rf_data must remain stable while rf_valid & !rf_ready.
- Status register updates on the pop cycle of an entry with set_flags=1, loaded with that entry's flags. It is unchanged otherwise.
- flags_pending = OR of set_flags over valid buffered entries.
- cond_pass, with status [Z,C,N,V] as source:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: !Z&(N==V)
  - 13 LE: Z|(N!=V)
  - 14 AL: 1
  - 15: 0 (reserved)
- Reset (any time, including mid-drain): buffer EMPTY, rf_valid=0, in_ready=1, status=FLAGS_RST, flags_pending=0, rf_addr=0, rf_data=0. In-flight entries are discarded.
- in_valid while in_ready=0: inputs ignored. The upstream must hold them.

Optional Feature:
- FLAG_FWD_EN defined: cond_pass and status use the flags of the youngest buffered entry with set_flags=1 if one exists, else the status register.
- FLAG_FWD_EN undefined: cond_pass and status use the status register only. Decode must stall on flags_pending.
- The flags_pending output exists in both builds.

Decomposition:
- Shared package (cpu_pkg): flag bit indices (FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_V=0), condition-code constants COND_EQ..COND_AL, and a uop width constant of 5.
- The package is shared with the ALU and decode.
- One sub-module: cond_eval (combinational, 4-bit flags + 4-bit cond -> pass). It is reused by the branch unit.

Test Plan:
1. Reset then single entry: result 0x00000001, rd=3, wr_en=1, set_flags=1, flags 4'b0000, rf_ready=1.
   - rf_valid high 1 cycle after accept with addr 3, data 0x1.
   - status=0000 after pop.
2. Backpressure: rf_ready=0, push 3 entries (rd 1,2,3; data 0xA,0xB,0xC).
   - in_ready drops after 2 accepts.
   - Release rf_ready: writes appear in order 1/0xA, 2/0xB; 3rd accepted after first pop.
3. CMP-type entry: wr_en=0, set_flags=1, flags 4'b1000 (Z), rf_ready=0.
   - Entry retires without rf_valid; status becomes 1000.
   - cond=EQ -> cond_pass=1; cond=NE -> 0.
4. Condition sweep: status forced via entries to {N=1,V=0} then {Z=0,C=1}.
   - First: LT=1, GE=0, MI=1.
   - Second: HI=1, LS=0; cond=15 -> 0, cond=14 -> 1.
5. Flag forwarding: entry with set_flags=1, flags 1000 held in buffer (rf_ready=0, wr_en=1).
   - flags_pending=1.
   - Without FLAG_FWD_EN: cond=EQ pass=0.
   - With FLAG_FWD_EN: pass=1.
6. Reset mid-operation: FULL buffer with rf_ready=0, assert rst asynchronously between clock edges.
   - rf_valid=0, in_ready=1, status=FLAGS_RST immediately; no writes after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: NZCV flag bit positions, ARM condition codes and uop width.
// Used by the ALU, decode, the branch unit and the ALU writeback stage.
package cpu_pkg;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  localparam int UOP_W = 5;

  typedef logic [3:0] flags_t;
  typedef logic [3:0] cond_t;

  localparam cond_t COND_EQ = 4'd0;
  localparam cond_t COND_NE = 4'd1;
  localparam cond_t COND_CS = 4'd2;
  localparam cond_t COND_CC = 4'd3;
  localparam cond_t COND_MI = 4'd4;
  localparam cond_t COND_PL = 4'd5;
  localparam cond_t COND_VS = 4'd6;
  localparam cond_t COND_VC = 4'd7;
  localparam cond_t COND_HI = 4'd8;
  localparam cond_t COND_LS = 4'd9;
  localparam cond_t COND_GE = 4'd10;
  localparam cond_t COND_LT = 4'd11;
  localparam cond_t COND_GT = 4'd12;
  localparam cond_t COND_LE = 4'd13;
  localparam cond_t COND_AL = 4'd14;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator over [Z,C,N,V] flags.
// Odd codes are the complement of the even code below them; 15 is reserved and never passes.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       pass
);

  logic z, c, n, v;
  logic base;

  always_comb begin
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    n = flags[FLAG_N];
    v = flags[FLAG_V];
    base = 1'b0;
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      3'd7: base = 1'b1;
      default: base = 1'b0;
    endcase
    pass = base ^ cond[0];
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: 2-entry skid buffer draining to the register-file write port,
// NZCV status register and condition evaluation. FLAG_FWD_EN forwards buffered flags.
//
// state    | meaning
// ---------|-------------------------------------------
// ST_EMPTY | no buffered entry, outputs idle
// ST_ONE   | slot0 holds the head entry
// ST_FULL  | slot0 head, slot1 younger; in_ready low
module alu_writeback
  import cpu_pkg::*;
#(
  parameter int         DATA_W    = 32,
  parameter int         RADDR_W   = 4,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_result,
  input  logic [3:0]         in_flags,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_wr_en,
  input  logic               in_set_flags,
  output logic               rf_valid,
  input  logic               rf_ready,
  output logic [RADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0]  rf_data,
  input  logic [3:0]         cond,
  output logic               cond_pass,
  output logic [3:0]         status,
  output logic               flags_pending
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Entry layout, LSB first: set_flags, wr_en, rd, flags, result
  localparam int ENT_W  = DATA_W + 4 + RADDR_W + 2;
  localparam int OFS_RD = 2;
  localparam int OFS_FL = 2 + RADDR_W;
  localparam int OFS_RS = 6 + RADDR_W;

  logic [1:0]       state_q, state_d;
  logic [ENT_W-1:0] slot0_q, slot0_d;
  logic [ENT_W-1:0] slot1_q, slot1_d;
  logic [3:0]       status_q, status_d;

  logic [ENT_W-1:0]   in_ent;
  logic               hd_valid;
  logic               hd_wr;
  logic               hd_sf;
  logic [RADDR_W-1:0] hd_rd;
  logic [3:0]         hd_flags;
  logic [DATA_W-1:0]  hd_res;
  logic               s1_valid;
  logic               s1_sf;
  logic [3:0]         s1_flags;
  logic               accept;
  logic               pop;
  logic [3:0]         flag_src;

  assign in_ent = {in_result, in_flags, in_rd, in_wr_en, in_set_flags};

  assign hd_valid = (state_q != ST_EMPTY);
  assign hd_sf    = slot0_q[0];
  assign hd_wr    = slot0_q[1];
  assign hd_rd    = slot0_q[OFS_RD +: RADDR_W];
  assign hd_flags = slot0_q[OFS_FL +: 4];
  assign hd_res   = slot0_q[OFS_RS +: DATA_W];

  assign s1_valid = (state_q == ST_FULL);
  assign s1_sf    = slot1_q[0];
  assign s1_flags = slot1_q[OFS_FL +: 4];

  // in_ready depends on registered occupancy only, never on rf_ready
  assign in_ready = (state_q != ST_FULL);
  assign accept   = in_valid & in_ready;
  assign pop      = hd_valid & (rf_ready | ~hd_wr);

  always_comb begin
    state_d  = state_q;
    slot0_d  = slot0_q;
    slot1_d  = slot1_q;
    status_d = status_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          slot0_d = in_ent;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          slot0_d = in_ent;
        end else if (accept) begin
          slot1_d = in_ent;
          state_d = ST_FULL;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          slot0_d = slot1_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (pop && hd_sf) begin
      status_d = hd_flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      slot0_q  <= '0;
      slot1_q  <= '0;
      status_q <= FLAGS_RST;
    end else begin
      state_q  <= state_d;
      slot0_q  <= slot0_d;
      slot1_q  <= slot1_d;
      status_q <= status_d;
    end
  end

  assign rf_valid      = hd_valid & hd_wr;
  assign rf_addr       = rf_valid ? hd_rd : '0;
  assign rf_data       = rf_valid ? hd_res : '0;
  assign flags_pending = (hd_valid & hd_sf) | (s1_valid & s1_sf);

  always_comb begin
`ifdef FLAG_FWD_EN
    // The youngest pending flag setter is what decode would see once the buffer drains
    if (s1_valid && s1_sf) begin
      flag_src = s1_flags;
    end else if (hd_valid && hd_sf) begin
      flag_src = hd_flags;
    end else begin
      flag_src = status_q;
    end
`else
    flag_src = status_q;
`endif
  end

  assign status = flag_src;

  cond_eval u_cond_eval (
    .flags (flag_src),
    .cond  (cond),
    .pass  (cond_pass)
  );

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus randomized traffic
// against a queue-based reference model. Honours FLAG_FWD_EN when defined.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_result = '0;
  logic [3:0]  in_flags = '0;
  logic [3:0]  in_rd = '0;
  logic        in_wr_en = 1'b0;
  logic        in_set_flags = 1'b0;
  logic        rf_valid;
  logic        rf_ready = 1'b0;
  logic [3:0]  rf_addr;
  logic [31:0] rf_data;
  logic [3:0]  cond = '0;
  logic        cond_pass;
  logic [3:0]  status;
  logic        flags_pending;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
    logic [3:0]  rd;
    logic        wr;
    logic        sf;
  } ent_t;

  ent_t       mq[$];
  logic [3:0] m_status = 4'b0000;

  always #5 clk = ~clk;

  alu_writeback dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_result     (in_result),
    .in_flags      (in_flags),
    .in_rd         (in_rd),
    .in_wr_en      (in_wr_en),
    .in_set_flags  (in_set_flags),
    .rf_valid      (rf_valid),
    .rf_ready      (rf_ready),
    .rf_addr       (rf_addr),
    .rf_data       (rf_data),
    .cond          (cond),
    .cond_pass     (cond_pass),
    .status        (status),
    .flags_pending (flags_pending)
  );

  function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] c);
    logic z, cy, n, v;
    z = f[3]; cy = f[2]; n = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Flags decode would see: status register, or youngest buffered setter when forwarding
  function automatic logic [3:0] ref_src();
    logic [3:0] s;
    s = m_status;
`ifdef FLAG_FWD_EN
    foreach (mq[i]) if (mq[i].sf) s = mq[i].fl;
`endif
    return s;
  endfunction

  function automatic logic ref_pending();
    logic p;
    p = 1'b0;
    foreach (mq[i]) p = p | mq[i].sf;
    return p;
  endfunction

  // Advance the model by one clock using the inputs present now, then move to the next negedge
  task automatic tick();
    int   pre_n;
    ent_t e;
    pre_n = mq.size();
    if (pre_n > 0 && (rf_ready || !mq[0].wr)) begin
      if (mq[0].sf) m_status = mq[0].fl;
      void'(mq.pop_front());
    end
    if (in_valid && pre_n < 2) begin
      e.res = in_result; e.fl = in_flags; e.rd = in_rd; e.wr = in_wr_en; e.sf = in_set_flags;
      mq.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [3:0] f,
                       input logic [3:0] rd, input logic wr, input logic sf);
    in_valid = v; in_result = r; in_flags = f; in_rd = rd; in_wr_en = wr; in_set_flags = sf;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || rf_valid !== 1'b0 || status !== 4'b0000 || flags_pending !== 1'b0
        || rf_addr !== 4'd0 || rf_data !== 32'd0) begin
      failures++;
      $display("FAIL reset: in_ready=%b rf_valid=%b status=%b pending=%b addr=%h data=%h, want 1 0 0000 0 0 0",
               in_ready, rf_valid, status, flags_pending, rf_addr, rf_data);
    end
    rst = 1'b0;
    mq.delete();
    m_status = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_single();
    rf_ready = 1'b1;
    drive(1'b1, 32'h1, 4'b0000, 4'd3, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 4'b0000, 4'd0, 1'b0, 1'b0);
    checks++;
    if (rf_valid !== 1'b1 || rf_addr !== 4'd3 || rf_data !== 32'h1 || flags_pending !== 1'b1) begin
      failures++;
      $display("FAIL single_write: valid=%b addr=%0d data=%h pending=%b, want 1 3 00000001 1",
               rf_valid, rf_addr, rf_data, flags_pending);
    end
    tick();
    checks++;
    if (rf_valid !== 1'b0 || status !== 4'b0000 || flags_pending !== 1'b0) begin
      failures++;
      $display("FAIL single_pop: valid=%b status=%b pending=%b, want 0 0000 0", rf_valid, status, flags_pending);
    end
  endtask

  task automatic test_backpressure();
    rf_ready = 1'b0;
    drive(1'b1, 32'hA, 4'b0000, 4'd1, 1'b1, 1'b0);
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_ready1: in_ready=%b want 1", in_ready);
    end
    drive(1'b1, 32'hB, 4'b0000, 4'd2, 1'b1, 1'b0);
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_full: in_ready=%b want 0", in_ready);
    end
    drive(1'b1, 32'hC, 4'b0000, 4'd3, 1'b1, 1'b0);
    tick();
    checks++;
    if (in_ready !== 1'b0 || rf_valid !== 1'b1 || rf_addr !== 4'd1 || rf_data !== 32'hA) begin
      failures++;
      $display("FAIL bp_stall: ready=%b valid=%b addr=%0d data=%h, want 0 1 1 0000000a",
               in_ready, rf_valid, rf_addr, rf_data);
    end
    rf_ready = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || rf_addr !== 4'd2 || rf_data !== 32'hB) begin
      failures++;
      $display("FAIL bp_second: ready=%b addr=%0d data=%h, want 1 2 0000000b", in_ready, rf_addr, rf_data);
    end
    tick();
    drive(1'b0, 32'h0, 4'b0000, 4'd0, 1'b0, 1'b0);
    checks++;
    if (rf_valid !== 1'b1 || rf_addr !== 4'd3 || rf_data !== 32'hC) begin
      failures++;
      $display("FAIL bp_third: valid=%b addr=%0d data=%h, want 1 3 0000000c", rf_valid, rf_addr, rf_data);
    end
    tick();
    checks++;
    if (rf_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_drain: valid=%b ready=%b want 0 1", rf_valid, in_ready);
    end
  endtask

  task automatic test_cmp();
    rf_ready = 1'b0;
    drive(1'b1, 32'h55, 4'b1000, 4'd5, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 4'b0000, 4'd0, 1'b0, 1'b0);
    checks++;
    if (rf_valid !== 1'b0 || flags_pending !== 1'b1) begin
      failures++; $display("FAIL cmp_buffered: valid=%b pending=%b want 0 1", rf_valid, flags_pending);
    end
    tick();
    cond = 4'd0; #1;
    checks++;
    if (status !== 4'b1000 || cond_pass !== 1'b1 || flags_pending !== 1'b0) begin
      failures++;
      $display("FAIL cmp_eq: status=%b pass=%b pending=%b want 1000 1 0", status, cond_pass, flags_pending);
    end
    cond = 4'd1; #1;
    checks++;
    if (cond_pass !== 1'b0) begin
      failures++; $display("FAIL cmp_ne: pass=%b want 0", cond_pass);
    end
  endtask

  task automatic set_status(input logic [3:0] f);
    drive(1'b1, 32'h0, f, 4'd0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 4'b0000, 4'd0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_cond_sweep();
    logic [3:0] want;
    set_status(4'b0010);
    want = 4'b0000;
    cond = 4'd11; #1; want[0] = cond_pass;
    cond = 4'd10; #1; want[1] = cond_pass;
    cond = 4'd4;  #1; want[2] = cond_pass;
    checks++;
    if (want !== 3'b101 || status !== 4'b0010) begin
      failures++;
      $display("FAIL cond_nv: MI/GE/LT=%b status=%b want 101 0010", want[2:0], status);
    end
    set_status(4'b0100);
    cond = 4'd8;  #1; want[0] = cond_pass;
    cond = 4'd9;  #1; want[1] = cond_pass;
    cond = 4'd15; #1; want[2] = cond_pass;
    cond = 4'd14; #1; want[3] = cond_pass;
    checks++;
    if (want !== 4'b1001) begin
      failures++; $display("FAIL cond_zc: AL/15/LS/HI=%b want 1001", want);
    end
    for (int c = 0; c < 16; c++) begin
      cond = 4'(c); #1;
      checks++;
      if (cond_pass !== ref_cond(4'b0100, 4'(c))) begin
        failures++;
        $display("FAIL cond_all c=%0d: pass=%b want %b", c, cond_pass, ref_cond(4'b0100, 4'(c)));
      end
    end
  endtask

  task automatic test_flag_fwd();
    logic exp_pass;
`ifdef FLAG_FWD_EN
    exp_pass = 1'b1;
`else
    exp_pass = 1'b0;
`endif
    rf_ready = 1'b0;
    drive(1'b1, 32'h77, 4'b1000, 4'd7, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 4'b0000, 4'd0, 1'b0, 1'b0);
    cond = 4'd0; #1;
    checks++;
    if (flags_pending !== 1'b1 || cond_pass !== exp_pass) begin
      failures++;
      $display("FAIL fwd_eq: pending=%b pass=%b want 1 %b", flags_pending, cond_pass, exp_pass);
    end
    rf_ready = 1'b1;
    tick();
    cond = 4'd0; #1;
    checks++;
    if (status !== 4'b1000 || cond_pass !== 1'b1 || flags_pending !== 1'b0) begin
      failures++;
      $display("FAIL fwd_commit: status=%b pass=%b pending=%b want 1000 1 0", status, cond_pass, flags_pending);
    end
  endtask

  task automatic test_reset_mid();
    rf_ready = 1'b0;
    drive(1'b1, 32'h11, 4'b0101, 4'd9, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'h22, 4'b0011, 4'd10, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 4'b0000, 4'd0, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || rf_valid !== 1'b1) begin
      failures++; $display("FAIL mid_full: ready=%b valid=%b want 0 1", in_ready, rf_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rf_valid !== 1'b0 || in_ready !== 1'b1 || status !== 4'b0000 || flags_pending !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: valid=%b ready=%b status=%b pending=%b want 0 1 0000 0",
               rf_valid, in_ready, status, flags_pending);
    end
    mq.delete();
    m_status = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    rf_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (rf_valid !== 1'b0) begin
        failures++; $display("FAIL mid_nowrite cyc=%0d: valid=%b want 0", i, rf_valid);
      end
    end
  endtask

  task automatic test_random();
    logic       exp_valid;
    logic [3:0] exp_addr;
    logic [31:0] exp_data;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!(in_valid && mq.size() >= 2)) begin
        drive(($urandom_range(0, 99) < 60), $urandom(), 4'($urandom()), 4'($urandom()),
              ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 50));
      end
      rf_ready = ($urandom_range(0, 99) < 55);
      cond = 4'($urandom());
      #1;
      exp_valid = (mq.size() > 0) && mq[0].wr;
      exp_addr  = exp_valid ? mq[0].rd : 4'd0;
      exp_data  = exp_valid ? mq[0].res : 32'd0;
      checks++;
      if (rf_valid !== exp_valid || rf_addr !== exp_addr || rf_data !== exp_data) begin
        failures++;
        $display("FAIL rnd_rf cyc=%0d: valid=%b addr=%h data=%h want %b %h %h",
                 cyc, rf_valid, rf_addr, rf_data, exp_valid, exp_addr, exp_data);
      end
      checks++;
      if (in_ready !== (mq.size() < 2) || flags_pending !== ref_pending()) begin
        failures++;
        $display("FAIL rnd_occ cyc=%0d: ready=%b pending=%b want %b %b",
                 cyc, in_ready, flags_pending, (mq.size() < 2), ref_pending());
      end
      checks++;
      if (status !== ref_src() || cond_pass !== ref_cond(ref_src(), cond)) begin
        failures++;
        $display("FAIL rnd_flags cyc=%0d: status=%b pass=%b want %b %b",
                 cyc, status, cond_pass, ref_src(), ref_cond(ref_src(), cond));
      end
      tick();
    end
    drive(1'b0, 32'h0, 4'b0000, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_cmp();
    test_cond_sweep();
    test_flag_fwd();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
